// File: rtl/sa_tile_sched_if.sv
// sa_tile_sched_if
//   Job handshake and systolic-array control bundle for sa_tile_sched.
//   slave modport  : the scheduler side (drives O_*, samples I_*).
//   master modport : the job source / SA wrapper / accumulator side.
//
//   I_JOB_VLD       job request valid
//   O_JOB_RDY       scheduler ready for a job (IDLE only)
//   I_JOB_KT        number of K-tiles in the job minus 1
//   O_SA_SYNC_RSTN  synchronous clear to the SA wrapper, active-low
//   O_SA_START      one-cycle start pulse to the SA wrapper
//   O_K_IDX         current K-tile index (selects X/W slice)
//   I_SA_OUT_VLD    SA wrapper output-valid level
//   O_ACC_EN        one-cycle accumulator capture pulse
//   O_ACC_FIRST     with O_ACC_EN: overwrite instead of add (tile 0)
//   O_DONE          one-cycle job-complete pulse
//   O_BUSY          scheduler is not IDLE
//   O_TIMEOUT       sticky WAIT timeout flag
interface sa_tile_sched_if #(
    parameter int KT_W = 3
);
    logic            I_JOB_VLD;
    logic            O_JOB_RDY;
    logic [KT_W-1:0] I_JOB_KT;
    logic            O_SA_SYNC_RSTN;
    logic            O_SA_START;
    logic [KT_W-1:0] O_K_IDX;
    logic            I_SA_OUT_VLD;
    logic            O_ACC_EN;
    logic            O_ACC_FIRST;
    logic            O_DONE;
    logic            O_BUSY;
    logic            O_TIMEOUT;

    modport slave (
        input  I_JOB_VLD, I_JOB_KT, I_SA_OUT_VLD,
        output O_JOB_RDY, O_SA_SYNC_RSTN, O_SA_START, O_K_IDX,
               O_ACC_EN, O_ACC_FIRST, O_DONE, O_BUSY, O_TIMEOUT
    );

    modport master (
        output I_JOB_VLD, I_JOB_KT, I_SA_OUT_VLD,
        input  O_JOB_RDY, O_SA_SYNC_RSTN, O_SA_START, O_K_IDX,
               O_ACC_EN, O_ACC_FIRST, O_DONE, O_BUSY, O_TIMEOUT
    );
endinterface

// File: rtl/sa_tile_sched.sv
// sa_tile_sched
//   Sequences one matrix job over up to KT_MAX K-tiles of a systolic array.
//   For every tile: clear the SA (CLR), start it (START), wait for a rising
//   edge of the SA output-valid (WAIT), then pulse the accumulator (ACC).
//   After the last tile a one-cycle DONE pulse is issued.
//
//   Parameters : KT_MAX (max tiles per job), KT_W (tile index width),
//                TO_CYC (WAIT timeout in cycles, timeout build only).
//   Ports      : I_CLK       rising-edge clock
//                I_ASYN_RST  asynchronous active-high reset
//                bus         sa_tile_sched_if.slave (job handshake, SA
//                            control, accumulator control, status)
//   Build option: define SA_SCHED_TIMEOUT_EN to add the WAIT timeout
//                counter and sticky O_TIMEOUT flag; otherwise O_TIMEOUT
//                is tied low and WAIT waits indefinitely.
module sa_tile_sched #(
    parameter int KT_MAX = 8,
    parameter int KT_W   = 3,
    parameter int TO_CYC = 1023
) (
    input  logic           I_CLK,
    input  logic           I_ASYN_RST,
    sa_tile_sched_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_ACC   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [KT_W-1:0] KT_LAST = KT_W'(KT_MAX - 1);

    state_t          state;
    state_t          state_nxt;
    logic [KT_W-1:0] k_q;
    logic [KT_W-1:0] kt_q;
    logic            vld_prev;
    logic            vld_rise;
    logic            to_hit;
    logic            accept;

    logic            job_rdy;
    logic            sa_rstn;
    logic            sa_start;
    logic            acc_en;
    logic            acc_first;
    logic            done;
    logic            busy;

    function automatic logic [KT_W-1:0] clamp_kt(input logic [KT_W-1:0] kt);
        return (kt > KT_LAST) ? KT_LAST : kt;
    endfunction

    // A high valid level carried into WAIT is not an edge: the history
    // register is cleared in CLR and reloaded from START onwards.
    assign vld_rise = bus.I_SA_OUT_VLD & ~vld_prev;
    assign accept   = (state == S_IDLE) & bus.I_JOB_VLD;

    always_ff @(posedge I_CLK or posedge I_ASYN_RST) begin
        if (I_ASYN_RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge I_CLK or posedge I_ASYN_RST) begin
        if (I_ASYN_RST) begin
            k_q      <= '0;
            kt_q     <= '0;
            vld_prev <= 1'b0;
        end else begin
            if (accept) begin
                kt_q <= clamp_kt(bus.I_JOB_KT);
                k_q  <= '0;
            end else if ((state == S_ACC) && (k_q != kt_q)) begin
                k_q <= k_q + 1'b1;
            end
            vld_prev <= (state == S_CLR) ? 1'b0 : bus.I_SA_OUT_VLD;
        end
    end

`ifdef SA_SCHED_TIMEOUT_EN
    localparam int TO_W = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);

    logic [TO_W-1:0] wait_cnt;
    logic            timeout_q;

    // wait_cnt holds the number of WAIT cycles already spent; the last
    // allowed WAIT cycle is the one where it equals TO_CYC-1.
    assign to_hit = (wait_cnt == TO_LAST);

    always_ff @(posedge I_CLK or posedge I_ASYN_RST) begin
        if (I_ASYN_RST) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == S_START) begin
                wait_cnt <= '0;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (accept) begin
                timeout_q <= 1'b0;
            end else if ((state == S_WAIT) && !vld_rise && to_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign bus.O_TIMEOUT = timeout_q;
`else
    logic to_cyc_unused;
    assign to_cyc_unused = (TO_CYC == 0);
    assign to_hit        = 1'b0;
    assign bus.O_TIMEOUT = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        job_rdy   = 1'b0;
        sa_rstn   = 1'b1;
        sa_start  = 1'b0;
        acc_en    = 1'b0;
        acc_first = 1'b0;
        done      = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                job_rdy = 1'b1;
                busy    = 1'b0;
                if (bus.I_JOB_VLD) begin
                    state_nxt = S_CLR;
                end
            end
            S_CLR: begin
                sa_rstn   = 1'b0;
                state_nxt = S_START;
            end
            S_START: begin
                sa_start  = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // A valid edge wins over a coincident timeout.
                if (vld_rise) begin
                    state_nxt = S_ACC;
                end else if (to_hit) begin
                    state_nxt = S_DONE;
                end
            end
            S_ACC: begin
                acc_en    = 1'b1;
                acc_first = (k_q == '0);
                state_nxt = (k_q == kt_q) ? S_DONE : S_CLR;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.O_JOB_RDY      = job_rdy;
    assign bus.O_SA_SYNC_RSTN = sa_rstn;
    assign bus.O_SA_START     = sa_start;
    assign bus.O_K_IDX        = k_q;
    assign bus.O_ACC_EN       = acc_en;
    assign bus.O_ACC_FIRST    = acc_first;
    assign bus.O_DONE         = done;
    assign bus.O_BUSY         = busy;

endmodule
